// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the FD and DE pipeline registers and the PC enable.
// Optional HAZARD_PERF_EN adds saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W        = 5,
  parameter int BRANCH_PENALTY    = 2,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter bit ZERO_REG_HW       = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  ex_mc_start,
  input  logic                  mc_done,
  output logic                  pc_write_en,
  output logic [1:0]            fd_flush,
  output logic [1:0]            fd_nop,
  output logic [1:0]            de_flush,
  output logic [1:0]            de_nop,
  output logic                  busy,
  output logic [1:0]            state_dbg
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]           perf_stall_cnt,
  output logic [15:0]           perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {S_RUN, S_LU_STALL, S_BR_FLUSH, S_MC_WAIT} state_t;
  typedef enum logic [1:0] {M_NORMAL, M_HOLD_LU, M_FLUSH_BR, M_HOLD_MC} mode_t;

  localparam logic [2:0] BR_INIT = 3'(BRANCH_PENALTY - 1);
  localparam logic [2:0] LU_INIT = 3'(LOAD_STALL_CYCLES - 1);

  state_t     state, state_nx;
  logic [2:0] cnt, cnt_nx;
  mode_t      mode;
  logic       lu_hit;

  always_comb begin
    lu_hit = ex_mem_read & ((id_rs1_used & (id_rs1 == ex_rd)) |
                            (id_rs2_used & (id_rs2 == ex_rd)));
    if (ZERO_REG_HW && (ex_rd == '0)) lu_hit = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Mode is the per-cycle output selection; it is decided alongside the next state.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mode     = M_NORMAL;
    case (state)
      S_RUN, S_LU_STALL: begin
        if (ex_branch_taken) begin
          mode     = M_FLUSH_BR;
          state_nx = S_RUN;
          if (BRANCH_PENALTY > 1) begin
            state_nx = S_BR_FLUSH;
            cnt_nx   = BR_INIT;
          end
        end else if (state == S_LU_STALL) begin
          mode   = M_HOLD_LU;
          cnt_nx = cnt - 3'd1;
          if (cnt <= 3'd1) state_nx = S_RUN;
        end else if (ex_mc_start) begin
          mode     = M_HOLD_MC;
          state_nx = S_MC_WAIT;
        end else if (lu_hit) begin
          mode = M_HOLD_LU;
          if (LOAD_STALL_CYCLES > 1) begin
            state_nx = S_LU_STALL;
            cnt_nx   = LU_INIT;
          end
        end
      end
      S_BR_FLUSH: begin
        mode   = M_FLUSH_BR;
        cnt_nx = cnt - 3'd1;
        if (cnt <= 3'd1) state_nx = S_RUN;
      end
      S_MC_WAIT: begin
        if (mc_done) begin
          mode     = M_NORMAL;
          state_nx = S_RUN;
        end else begin
          mode = M_HOLD_MC;
        end
      end
      default: state_nx = S_RUN;
    endcase
  end

  always_comb begin
    pc_write_en = 1'b1;
    fd_flush    = 2'b00;
    fd_nop      = 2'b00;
    de_flush    = 2'b00;
    de_nop      = 2'b00;
    busy        = (state != S_RUN);
    state_dbg   = state;
    if (!reset) begin
      pc_write_en = 1'b0;
      fd_flush    = 2'b01;
      de_flush    = 2'b01;
    end else begin
      case (mode)
        M_HOLD_LU: begin
          pc_write_en = 1'b0;
          fd_nop      = 2'b01;
          de_flush    = 2'b01;
        end
        M_FLUSH_BR: begin
          fd_flush = 2'b01;
          de_flush = 2'b01;
        end
        M_HOLD_MC: begin
          pc_write_en = 1'b0;
          fd_nop      = 2'b01;
          de_nop      = 2'b01;
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= 16'd0;
      perf_flush_cnt <= 16'd0;
    end else begin
      if (!pc_write_en && (perf_stall_cnt != 16'hFFFF))
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if ((fd_flush == 2'b01) && (perf_flush_cnt != 16'hFFFF))
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two configurations driven by shared inputs,
// checked every cycle against a cycle-count model of the stall/flush rules.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, ex_mem_read;
  logic       ex_branch_taken, ex_mc_start, mc_done;

  logic       pc0, busy0, pc1, busy1;
  logic [1:0] fdf0, fdn0, def0, den0, st0;
  logic [1:0] fdf1, fdn1, def1, den1, st1;
`ifdef HAZARD_PERF_EN
  logic [15:0] pstall0, pflush0, pstall1, pflush1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .BRANCH_PENALTY(2), .LOAD_STALL_CYCLES(1),
                         .ZERO_REG_HW(1'b1)) u_dut0 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_mc_start(ex_mc_start), .mc_done(mc_done), .pc_write_en(pc0),
    .fd_flush(fdf0), .fd_nop(fdn0), .de_flush(def0), .de_nop(den0),
    .busy(busy0), .state_dbg(st0)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(pstall0), .perf_flush_cnt(pflush0)
`endif
  );

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .BRANCH_PENALTY(3), .LOAD_STALL_CYCLES(3),
                         .ZERO_REG_HW(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_mc_start(ex_mc_start), .mc_done(mc_done), .pc_write_en(pc1),
    .fd_flush(fdf1), .fd_nop(fdn1), .de_flush(def1), .de_nop(den1),
    .busy(busy1), .state_dbg(st1)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(pstall1), .perf_flush_cnt(pflush1)
`endif
  );

  // Reference model: remaining penalty cycles per instance, plain integers.
  int pen[2]  = '{2, 3};
  int lst[2]  = '{1, 3};
  bit zreg[2] = '{1'b1, 1'b0};
  int br_left[2], lu_left[2], perf_s[2], perf_f[2];
  bit mc_act[2];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Modes: 0 normal, 1 hold for load-use, 2 branch flush, 3 hold for multi-cycle, 4 reset.
  function automatic logic [9:0] mode_bits(input int m, input bit b);
    case (m)
      1: return {1'b0, 2'b00, 2'b01, 2'b01, 2'b00, b};
      2: return {1'b1, 2'b01, 2'b00, 2'b01, 2'b00, b};
      3: return {1'b0, 2'b00, 2'b01, 2'b00, 2'b01, b};
      4: return {1'b0, 2'b01, 2'b00, 2'b01, 2'b00, 1'b0};
      default: return {1'b1, 2'b00, 2'b00, 2'b00, 2'b00, b};
    endcase
  endfunction

  task automatic model_step(input int i, output logic [9:0] exp);
    int m;
    bit b, hit;
    hit = ex_mem_read && ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd))
          && !(zreg[i] && ex_rd == 5'd0);
    b = (br_left[i] > 0) || (lu_left[i] > 0) || mc_act[i];
    if (!reset) begin
      m = 4; br_left[i] = 0; lu_left[i] = 0; mc_act[i] = 1'b0;
      perf_s[i] = 0; perf_f[i] = 0;
    end else if (br_left[i] > 0) begin
      m = 2; br_left[i]--;
    end else if (mc_act[i]) begin
      if (mc_done) begin m = 0; mc_act[i] = 1'b0; end
      else m = 3;
    end else if (ex_branch_taken) begin
      m = 2; lu_left[i] = 0; br_left[i] = pen[i] - 1;
    end else if (lu_left[i] > 0) begin
      m = 1; lu_left[i]--;
    end else if (ex_mc_start) begin
      m = 3; mc_act[i] = 1'b1;
    end else if (hit) begin
      m = 1; lu_left[i] = lst[i] - 1;
    end else begin
      m = 0;
    end
    exp = mode_bits(m, b);
  endtask

  task automatic cycle(input string tag);
    logic [9:0] e0, e1;
    int ps0, pf0, ps1, pf1;
    #1;
    model_step(0, e0);
    model_step(1, e1);
    ps0 = perf_s[0]; pf0 = perf_f[0]; ps1 = perf_s[1]; pf1 = perf_f[1];
    check({tag, "/cfg0"}, {6'd0, pc0, fdf0, fdn0, def0, den0, busy0}, {6'd0, e0});
    check({tag, "/cfg1"}, {6'd0, pc1, fdf1, fdn1, def1, den1, busy1}, {6'd0, e1});
`ifdef HAZARD_PERF_EN
    check({tag, "/stall0"}, pstall0, 16'(ps0));
    check({tag, "/flush0"}, pflush0, 16'(pf0));
    check({tag, "/stall1"}, pstall1, 16'(ps1));
    check({tag, "/flush1"}, pflush1, 16'(pf1));
`endif
    if (reset) begin
      if (!e0[9] && perf_s[0] < 65535) perf_s[0]++;
      if (e0[8:7] == 2'b01 && perf_f[0] < 65535) perf_f[0]++;
      if (!e1[9] && perf_s[1] < 65535) perf_s[1]++;
      if (e1[8:7] == 2'b01 && perf_f[1] < 65535) perf_f[1]++;
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit rst, input bit bt, input bit ms, input bit md,
                       input bit mr, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input bit u1, input bit u2);
    reset = rst; ex_branch_taken = bt; ex_mc_start = ms; mc_done = md;
    ex_mem_read = mr; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
    id_rs1_used = u1; id_rs2_used = u2;
  endtask

  task automatic idle(input int n, input string tag);
    drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    for (int k = 0; k < n; k++) cycle(tag);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      br_left[i] = 0; lu_left[i] = 0; mc_act[i] = 1'b0; perf_s[i] = 0; perf_f[i] = 0;
    end
    drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) cycle("reset");
    idle(2, "post_reset");

    drive(1, 0, 0, 0, 1, 5'd1, 5'd5, 5'd5, 0, 1);
    cycle("load_use");
    idle(4, "load_use_after");

    drive(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
    cycle("zero_reg");
    idle(4, "zero_reg_after");

    drive(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    cycle("branch");
    idle(3, "branch_after");

    drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    cycle("mc_start");
    idle(3, "mc_wait");
    drive(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    cycle("mc_done");
    idle(1, "mc_after");

    drive(1, 1, 0, 0, 1, 5'd7, 5'd0, 5'd7, 1, 0);
    cycle("br_vs_lu");
    idle(3, "br_vs_lu_after");

    drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    cycle("mc_then_reset");
    idle(1, "mc_wait2");
    drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    cycle("reset_mid_mc");
    idle(3, "after_abort");

    drive(1, 0, 0, 0, 1, 5'd3, 5'd0, 5'd3, 1, 0);
    cycle("lu_then_br");
    drive(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    cycle("br_in_lu");
    idle(4, "br_in_lu_after");

    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 39) != 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      cycle("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage core. It drives the `flush`/`nop` control pairs of the Fetch/Decode and Decode/Execute pipeline registers, plus the PC write enable.
- Detects load-use hazards, taken branches resolved in Execute, and multi-cycle Execute operations.
- Sequences the required bubble/hold cycles with a small FSM and down-counter.

Parameters:
- REG_ADDR_W, 5, width of register-file addresses.
- BRANCH_PENALTY, 2, cycles of FD+DE flush after a taken branch (1..7).
- LOAD_STALL_CYCLES, 1, hold cycles inserted per load-use hazard (1..7).
- ZERO_REG_HW, 1, if 1, register address 0 never creates a hazard.

Ports:
- clk  in  1  core clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- id_rs1  in  REG_ADDR_W  Decode source register 1.
- id_rs2  in  REG_ADDR_W  Decode source register 2.
- id_rs1_used  in  1  Decode instruction reads rs1.
- id_rs2_used  in  1  Decode instruction reads rs2.
- ex_rd  in  REG_ADDR_W  Execute destination register.
- ex_mem_read  in  1  Execute instruction is a load.
- ex_branch_taken  in  1  taken branch/jump resolved in Execute (1-cycle pulse).
- ex_mc_start  in  1  multi-cycle op entered Execute (1-cycle pulse).
- mc_done  in  1  multi-cycle unit result ready (1-cycle pulse).
- pc_write_en  out  1  1 = PC advances.
- fd_flush  out  2  Fetch/Decode flush: 00 normal, 01 bubble.
- fd_nop  out  2  Fetch/Decode hold: 00 advance, 01 hold.
- de_flush  out  2  Decode/Execute flush: 00 normal, 01 bubble.
- de_nop  out  2  Decode/Execute hold: 00 advance, 01 hold.
- busy  out  1  FSM not in RUN.

Behaviour:
- **Hazard detection (combinational):**
  - `lu_hit = ex_mem_read & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd))`.
  - When ZERO_REG_HW=1, `ex_rd==0` masks `lu_hit`.
- **Output encoding per mode (combinational from state and inputs):**
  - NORMAL: pc_write_en=1, all flush/nop=00.
  - HOLD_LU: pc_write_en=0, fd_nop=01, fd_flush=00, de_flush=01, de_nop=00.
  - FLUSH_BR: pc_write_en=1, fd_flush=01, de_flush=01, nops=00.
  - HOLD_MC: pc_write_en=0, fd_nop=01, de_nop=01, flushes=00.
  - Value 2'b10/2'b11 is never driven.
- **States:** RUN, LU_STALL, BR_FLUSH, MC_WAIT. A 3-bit down-counter `cnt` is used by LU_STALL and BR_FLUSH.
- **RUN:**
  - `ex_branch_taken` → FLUSH_BR outputs this cycle. If BRANCH_PENALTY>1, go to BR_FLUSH with cnt=BRANCH_PENALTY-1.
  - else `ex_mc_start` → HOLD_MC this cycle; go to MC_WAIT.
  - else `lu_hit` → HOLD_LU this cycle. If LOAD_STALL_CYCLES>1, go to LU_STALL with cnt=LOAD_STALL_CYCLES-1.
  - else NORMAL.
- **BR_FLUSH:**
  - FLUSH_BR outputs; decrement cnt.
  - Return to RUN after the cycle with cnt==1.
  - A new `ex_branch_taken` here is ignored, since Execute holds a bubble.
- **LU_STALL:**
  - HOLD_LU outputs; decrement cnt; return to RUN after cnt==1.
  - `ex_branch_taken` has priority: FLUSH_BR outputs this cycle and enter BR_FLUSH/RUN exactly as from RUN.
- **MC_WAIT:**
  - HOLD_MC outputs until `mc_done`.
  - In the `mc_done` cycle, outputs are NORMAL and the FSM returns to RUN.
  - `ex_branch_taken` is not possible in MC_WAIT and is ignored.
- **Priority in the same cycle:** branch > multi-cycle start > load-use.
- **Reset:**
  - While reset==0, state is forced to RUN and cnt to 0.
  - Outputs while reset==0: pc_write_en=0, fd_flush=01, de_flush=01, nops=00, busy=0.
  - Reset asserted mid-stall aborts the stall immediately. The first cycle after release evaluates from RUN.
- **Timing:** zero-cycle latency from hazard inputs to outputs. State updates on the next rising edge. Outputs have no combinational path from `busy`.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds outputs `perf_stall_cnt[15:0]` and `perf_flush_cnt[15:0]`.
  - `perf_stall_cnt` increments each cycle pc_write_en==0 outside reset.
  - `perf_flush_cnt` increments each cycle fd_flush==01 outside reset.
  - Both counters saturate at 16'hFFFF and clear on reset.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset=0 for 3 cycles, then release, all inputs idle → pc_write_en=0 and fd/de_flush=01 while reset=0, then NORMAL (pc_write_en=1, all 00), busy=0.
2. ex_mem_read=1, ex_rd=5, id_rs2=5, id_rs2_used=1, LOAD_STALL_CYCLES=1 → exactly one HOLD_LU cycle (pc_write_en=0, fd_nop=01, de_flush=01), then NORMAL.
3. Same as scenario 2 with ex_rd=0 and ZERO_REG_HW=1 → no stall; NORMAL throughout.
4. ex_branch_taken pulse, BRANCH_PENALTY=2 → 2 cycles of fd_flush=de_flush=01 with pc_write_en=1; busy=1 only in the second cycle; then RUN.
5. ex_mc_start pulse, mc_done 4 cycles later → 4 HOLD_MC cycles (fd_nop=de_nop=01, pc_write_en=0), NORMAL in the mc_done cycle.
6. In the same cycle, ex_branch_taken=1 and lu_hit=1 → FLUSH_BR wins. Separately, reset=0 asserted during MC_WAIT → state RUN after release, with no hold.
